// File: rtl/scoreboard_hazard.sv
// Issue/stall/flush decision for the ID stage: a per-register countdown scoreboard
// for variable-latency results plus a shift-register reservation of the single WB port.
module scoreboard_hazard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int MAX_LAT = 7,
  parameter int LW      = 3,
  parameter int FWD     = 1,
  parameter int CW      = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic            id_rs1_en,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_rs2_en,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_rd_we,
  input  logic [LW-1:0]   id_lat,
  input  logic            br_taken_ex,
  output logic            stall,
  output logic            flush_id,
  output logic            issue,
  output logic            fwd_rs1,
  output logic            fwd_rs2,
  output logic [NREG-1:0] busy_mask,
  output logic [CW-1:0]   stall_cnt
);

  localparam logic [LW-1:0] ONE_L     = LW'(1);
  localparam logic [LW-1:0] MAX_LAT_L = LW'(MAX_LAT);
  localparam bit            HAS_FWD   = (FWD != 0);

  logic [LW-1:0]      cnt_q [NREG];
  logic [LW-1:0]      cnt_d [NREG];
  logic [MAX_LAT-1:0] wb_slot_q, wb_slot_d, slot_shift;
  logic [CW-1:0]      stall_cnt_q, stall_cnt_d;

  logic [LW-1:0] lat_eff;
  logic [LW-1:0] rs1_cnt, rs2_cnt, rd_cnt;
  logic          rs1_live, rs2_live, rd_live;
  logic          src1_haz, src2_haz, waw_haz, port_haz, haz;

  always_comb begin
    lat_eff = id_lat;
    if (id_lat == '0)
      lat_eff = ONE_L;
    else if (id_lat > MAX_LAT_L)
      lat_eff = MAX_LAT_L;
  end

  always_comb begin
    rs1_cnt  = cnt_q[id_rs1];
    rs2_cnt  = cnt_q[id_rs2];
    rd_cnt   = cnt_q[id_rd];
    rs1_live = id_rs1_en && (id_rs1 != '0);
    rs2_live = id_rs2_en && (id_rs2 != '0);
    rd_live  = id_rd_we && (id_rd != '0);

    if (HAS_FWD) begin
      src1_haz = rs1_live && (rs1_cnt > ONE_L);
      src2_haz = rs2_live && (rs2_cnt > ONE_L);
    end else begin
      src1_haz = rs1_live && (rs1_cnt != '0);
      src2_haz = rs2_live && (rs2_cnt != '0);
    end

    waw_haz = rd_live && (rd_cnt > lat_eff);

    // The port check looks at the same post-shift vector the reservation is
    // written into, so an ALU op may follow an ALU op back to back.
    slot_shift = wb_slot_q >> 1;
    port_haz   = id_rd_we && slot_shift[lat_eff - ONE_L];

    haz = id_valid && (src1_haz || src2_haz || waw_haz || port_haz);
  end

  always_comb begin
    flush_id = !rstn || br_taken_ex;
    stall    = rstn && haz && !br_taken_ex;
    issue    = rstn && id_valid && !stall && !flush_id;
    fwd_rs1  = HAS_FWD && issue && rs1_live && (rs1_cnt == ONE_L);
    fwd_rs2  = HAS_FWD && issue && rs2_live && (rs2_cnt == ONE_L);
  end

  always_comb begin
    busy_mask = '0;
    for (int unsigned r = 0; r < NREG; r++)
      busy_mask[r] = (cnt_q[r] != '0);
    stall_cnt = stall_cnt_q;
  end

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++)
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - ONE_L : '0;
    if (issue && rd_live)
      cnt_d[id_rd] = lat_eff;
    cnt_d[0] = '0;

    wb_slot_d = slot_shift;
    if (issue && id_rd_we)
      wb_slot_d[lat_eff - ONE_L] = 1'b1;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < NREG; r++)
        cnt_q[r] <= '0;
      wb_slot_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++)
        cnt_q[r] <= cnt_d[r];
      wb_slot_q   <= wb_slot_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard.sv
// Directed bench for scoreboard_hazard: the driver queues hand-computed expectations
// per cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_scoreboard_hazard;

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_en, id_rs2_en, id_rd_we;
  logic [2:0]  id_lat;
  logic        br_taken_ex;
  logic        stall, flush_id, issue, fwd_rs1, fwd_rs2;
  logic [31:0] busy_mask;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int step_id  = 0;

  typedef struct {
    int          id;
    logic        st, fl, is, f1, f2;
    logic [31:0] busy, scnt;
  } exp_t;

  exp_t exp_q[$];

  scoreboard_hazard #(
    .NREG(32), .AW(5), .MAX_LAT(7), .LW(3), .FWD(1), .CW(32)
  ) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_en(id_rs1_en),
    .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_lat(id_lat),
    .br_taken_ex(br_taken_ex),
    .stall(stall), .flush_id(flush_id), .issue(issue),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, int id, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endfunction

  // Monitor: the DUT presents a decision every cycle; compare mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("stall",     e.id, 32'(stall),    32'(e.st));
        check("flush_id",  e.id, 32'(flush_id), 32'(e.fl));
        check("issue",     e.id, 32'(issue),    32'(e.is));
        check("fwd_rs1",   e.id, 32'(fwd_rs1),  32'(e.f1));
        check("fwd_rs2",   e.id, 32'(fwd_rs2),  32'(e.f2));
        check("busy_mask", e.id, busy_mask,     e.busy);
        check("stall_cnt", e.id, stall_cnt,     e.scnt);
      end
    end
  end

  task automatic step(input int v, input int rs1, input int e1, input int rs2, input int e2,
                      input int rd, input int we, input int lat, input int br, input int rn,
                      input int st, input int fl, input int is, input int f1, input int f2,
                      input logic [31:0] busy, input logic [31:0] scnt);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid    = v[0];
    id_rs1      = rs1[4:0];
    id_rs1_en   = e1[0];
    id_rs2      = rs2[4:0];
    id_rs2_en   = e2[0];
    id_rd       = rd[4:0];
    id_rd_we    = we[0];
    id_lat      = lat[2:0];
    br_taken_ex = br[0];
    rstn        = rn[0];
    e.id   = step_id;
    e.st   = st[0];
    e.fl   = fl[0];
    e.is   = is[0];
    e.f1   = f1[0];
    e.f2   = f2[0];
    e.busy = busy;
    e.scnt = scnt;
    exp_q.push_back(e);
    step_id++;
  endtask

  task automatic idle(input logic [31:0] busy, input logic [31:0] scnt);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, busy, scnt);
  endtask

  initial begin
    rstn = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs1_en = 1'b0; id_rs2 = '0;
    id_rs2_en = 1'b0; id_rd = '0; id_rd_we = 1'b0; id_lat = '0; br_taken_ex = 1'b0;

    // reset with a live instruction in ID: nothing issues, flush held
    step(1, 5, 1, 0, 0, 5, 1, 1, 0, 0,  0, 1, 0, 0, 0, 32'h0, 0);
    // back-to-back ALU dependence
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, 1,  0, 0, 1, 0, 0, 32'h0, 0);
    step(1, 5, 1, 0, 0, 6, 1, 1, 0, 1,  0, 0, 1, 1, 0, 32'h20, 0);
    // load-use: one stall then forwarded issue
    step(1, 0, 0, 0, 0, 7, 1, 2, 0, 1,  0, 0, 1, 0, 0, 32'h40, 0);
    step(1, 7, 1, 0, 0, 8, 1, 1, 0, 1,  1, 0, 0, 0, 0, 32'h80, 0);
    step(1, 7, 1, 0, 0, 8, 1, 1, 0, 1,  0, 0, 1, 1, 0, 32'h80, 1);
    // divider to x10, unrelated ALU writes, then consumer of x10
    step(1, 0, 0, 0, 0, 10, 1, 7, 0, 1, 0, 0, 1, 0, 0, 32'h100, 1);
    step(1, 0, 0, 0, 0, 11, 1, 1, 0, 1, 0, 0, 1, 0, 0, 32'h400, 1);
    step(1, 0, 0, 0, 0, 11, 1, 1, 0, 1, 0, 0, 1, 0, 0, 32'hC00, 1);
    step(1, 10, 1, 0, 0, 12, 1, 1, 0, 1, 1, 0, 0, 0, 0, 32'hC00, 1);
    step(1, 10, 1, 0, 0, 12, 1, 1, 0, 1, 1, 0, 0, 0, 0, 32'h400, 2);
    step(1, 10, 1, 0, 0, 12, 1, 1, 0, 1, 1, 0, 0, 0, 0, 32'h400, 3);
    step(1, 10, 1, 0, 0, 12, 1, 1, 0, 1, 1, 0, 0, 0, 0, 32'h400, 4);
    step(1, 10, 1, 0, 0, 12, 1, 1, 0, 1, 0, 0, 1, 1, 0, 32'h400, 5);
    // writeback port conflict: lat3 then lat2 one cycle later
    step(1, 0, 0, 0, 0, 3, 1, 3, 0, 1,  0, 0, 1, 0, 0, 32'h1000, 5);
    step(1, 0, 0, 0, 0, 4, 1, 2, 0, 1,  1, 0, 0, 0, 0, 32'h8, 5);
    step(1, 0, 0, 0, 0, 4, 1, 2, 0, 1,  0, 0, 1, 0, 0, 32'h8, 6);
    idle(32'h18, 6);
    idle(32'h10, 6);
    // WAW: lat3 to x3 then lat1 to x3
    step(1, 0, 0, 0, 0, 3, 1, 3, 0, 1,  0, 0, 1, 0, 0, 32'h0, 6);
    step(1, 0, 0, 0, 0, 3, 1, 1, 0, 1,  1, 0, 0, 0, 0, 32'h8, 6);
    step(1, 0, 0, 0, 0, 3, 1, 1, 0, 1,  1, 0, 0, 0, 0, 32'h8, 7);
    step(1, 0, 0, 0, 0, 3, 1, 1, 0, 1,  0, 0, 1, 0, 0, 32'h8, 8);
    idle(32'h8, 8);
    // flush beats stall; killed consumer leaves the scoreboard alone
    step(1, 0, 0, 0, 0, 7, 1, 4, 0, 1,  0, 0, 1, 0, 0, 32'h0, 8);
    step(1, 7, 1, 0, 0, 9, 1, 1, 0, 1,  1, 0, 0, 0, 0, 32'h80, 8);
    step(1, 7, 1, 0, 0, 9, 1, 1, 1, 1,  0, 1, 0, 0, 0, 32'h80, 9);
    idle(32'h80, 9);
    idle(32'h80, 9);
    idle(32'h0, 9);
    // reset mid-countdown discards the pending x10
    step(1, 0, 0, 0, 0, 10, 1, 7, 0, 1, 0, 0, 1, 0, 0, 32'h0, 9);
    idle(32'h400, 9);
    idle(32'h400, 9);
    step(1, 10, 1, 0, 0, 13, 1, 1, 0, 0, 0, 1, 0, 0, 0, 32'h400, 9);
    step(1, 10, 1, 0, 0, 13, 1, 1, 0, 1, 0, 0, 1, 0, 0, 32'h0, 0);
    // rs2 forwarding, rs1=x0 ignored, x0 write still reserves the port
    step(1, 0, 1, 13, 1, 0, 1, 2, 0, 1, 0, 0, 1, 0, 1, 32'h2000, 0);
    step(1, 0, 0, 0, 0, 14, 1, 1, 0, 1, 1, 0, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 0, 0, 14, 1, 1, 0, 1, 0, 0, 1, 0, 0, 32'h0, 1);
    // id_lat=0 behaves as latency 1
    step(1, 14, 1, 0, 0, 15, 1, 0, 0, 1, 0, 0, 1, 1, 0, 32'h4000, 1);
    // same register as rd and both sources: sources see the old count
    step(1, 15, 1, 15, 1, 15, 1, 1, 0, 1, 0, 0, 1, 1, 1, 32'h8000, 1);
    idle(32'h8000, 1);
    idle(32'h0, 1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
